// File: rtl/fpnew_sdotp_out_buffer.sv
// Circular result FIFO behind the SDOTP unit with sticky fflags.
// Optional macro FPNEW_SDOTP_OUT_FALL_THROUGH_EN: empty-buffer bypass.
module fpnew_sdotp_out_buffer #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 2,
  parameter type TagType = logic,
  parameter type AuxType = logic,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [Width-1:0] result_i,
  input  logic [4:0]      status_i,
  input  logic            extension_bit_i,
  input  TagType          tag_i,
  input  AuxType          aux_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic            flush_i,
  output logic [Width-1:0] result_o,
  output logic [4:0]      status_o,
  output logic            extension_bit_o,
  output TagType          tag_o,
  output AuxType          aux_o,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  input  logic            fflags_clr_i,
  output logic [4:0]      fflags_o,
  output logic [CntW-1:0] count_o,
  output logic            busy_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  typedef struct packed {
    logic [Width-1:0] result;
    logic [4:0]       status;
    logic             ext;
    TagType           tag;
    AuxType           aux;
  } entry_t;

  entry_t          mem [Depth];
  entry_t          in_entry;
  entry_t          head;
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [CntW-1:0] count;
  logic [4:0]      fflags;
  logic            empty;
  logic            full;
  logic            push;
  logic            pop;
  logic            store;
  logic            drain;

  function automatic logic [PtrW-1:0] nxt(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign in_entry = '{
    result: result_i,
    status: status_i,
    ext:    extension_bit_i,
    tag:    tag_i,
    aux:    aux_i
  };

  assign empty      = (count == '0);
  assign full       = (count == CntW'(Depth));
  assign in_ready_o = !full;

`ifdef FPNEW_SDOTP_OUT_FALL_THROUGH_EN
  // Empty buffer exposes the incoming entry directly.
  assign out_valid_o = !empty || in_valid_i;
  assign head        = empty ? in_entry : mem[rd_ptr];
`else
  assign out_valid_o = !empty;
  assign head        = mem[rd_ptr];
`endif

  assign push = in_valid_i && in_ready_o && !flush_i;
  assign pop  = out_valid_o && out_ready_i && !flush_i;

  // A pop on an empty buffer is a bypassed entry: nothing stored.
  assign store = push && !(empty && pop);
  assign drain = pop && !empty;

  assign result_o        = head.result;
  assign status_o        = head.status;
  assign extension_bit_o = head.ext;
  assign tag_o           = head.tag;
  assign aux_o           = head.aux;
  assign fflags_o        = fflags;
  assign count_o         = count;
  assign busy_o          = !empty;

  // Pointer and occupancy bookkeeping; flush empties the ring.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (store) wr_ptr <= nxt(wr_ptr);
      if (drain) rd_ptr <= nxt(rd_ptr);
      if (store && !drain) begin
        count <= count + CntW'(1);
      end else if (!store && drain) begin
        count <= count - CntW'(1);
      end
    end
  end

  // Entry storage, written at the tail on an accepted push.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem[i] <= '0;
      end
    end else if (store) begin
      mem[wr_ptr] <= in_entry;
    end
  end

  // Sticky flags: clear first, then merge the retiring status.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fflags <= '0;
    end else begin
      fflags <= (fflags_clr_i ? 5'b0 : fflags)
              | (pop ? head.status : 5'b0);
    end
  end

endmodule

// File: tb/tb_fpnew_sdotp_out_buffer.sv
// Scoreboard bench for fpnew_sdotp_out_buffer (Depth 2).
// Reference: a queue of accepted entries plus an OR-accumulator.
module tb_fpnew_sdotp_out_buffer;

  localparam int DEPTH = 2;
  typedef logic [2:0] tag_t;
  typedef logic [3:0] aux_t;

  typedef struct {
    logic [63:0] r;
    logic [4:0]  s;
    logic        e;
    tag_t        t;
    aux_t        a;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] result_i = '0;
  logic [4:0]  status_i = '0;
  logic        ext_i = 1'b0;
  tag_t        tag_i = '0;
  aux_t        aux_i = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic [63:0] result_o;
  logic [4:0]  status_o;
  logic        ext_o;
  tag_t        tag_o;
  aux_t        aux_o;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        clr = 1'b0;
  logic [4:0]  fflags;
  logic [1:0]  count;
  logic        busy;

  int   n_vec = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;
  exp_t sb[$];
  logic [4:0] m_flags = '0;
  int   pre_sz = 0;
  bit   bypassed = 1'b0;

  fpnew_sdotp_out_buffer #(
    .Width(64), .Depth(DEPTH),
    .TagType(tag_t), .AuxType(aux_t)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .result_i(result_i),
    .status_i(status_i),
    .extension_bit_i(ext_i),
    .tag_i(tag_i),
    .aux_i(aux_i),
    .in_valid_i(in_valid),
    .in_ready_o(in_ready),
    .flush_i(flush),
    .result_o(result_o),
    .status_o(status_o),
    .extension_bit_o(ext_o),
    .tag_o(tag_o),
    .aux_o(aux_o),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .fflags_clr_i(clr),
    .fflags_o(fflags),
    .count_o(count),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Monitor: state checks, then pop/compare on a handshake.
  always @(negedge clk) begin
    exp_t e;
    bit   popped;
    #1;
    popped   = 1'b0;
    bypassed = 1'b0;
    pre_sz   = sb.size();
    if (rst_n && mon_en) begin
      chk("count", 64'(count), 64'(pre_sz));
      chk("busy", 64'(busy), 64'(pre_sz != 0));
      chk("in_ready", 64'(in_ready), 64'(pre_sz < DEPTH));
      chk("fflags", 64'(fflags), 64'(m_flags));
`ifdef FPNEW_SDOTP_OUT_FALL_THROUGH_EN
      chk("out_valid", 64'(out_valid),
          64'((pre_sz != 0) || in_valid));
`else
      chk("out_valid", 64'(out_valid), 64'(pre_sz != 0));
`endif
      if (out_valid && out_ready && !flush) begin
        if (pre_sz != 0) begin
          e = sb.pop_front();
          popped = 1'b1;
        end else begin
`ifdef FPNEW_SDOTP_OUT_FALL_THROUGH_EN
          e = '{r: result_i, s: status_i, e: ext_i,
                t: tag_i, a: aux_i};
          popped   = 1'b1;
          bypassed = 1'b1;
`else
          chk("pop_underflow", 64'(1), 64'(0));
`endif
        end
        if (popped) begin
          chk("result", result_o, e.r);
          chk("status", 64'(status_o), 64'(e.s));
          chk("ext", 64'(ext_o), 64'(e.e));
          chk("tag", 64'(tag_o), 64'(e.t));
          chk("aux", 64'(aux_o), 64'(e.a));
        end
      end
      m_flags = (clr ? 5'b0 : m_flags) | (popped ? e.s : 5'b0);
    end
  end

  // Stimulus side: record accepted entries as expected results.
  always @(negedge clk) begin
    #2;
    if (rst_n && mon_en) begin
      if (flush) begin
        sb.delete();
      end else if (in_valid && pre_sz < DEPTH && !bypassed) begin
        sb.push_back('{r: result_i, s: status_i, e: ext_i,
                       t: tag_i, a: aux_i});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [63:0] r, logic [4:0] s, tag_t t);
    in_valid = 1'b1;
    result_i = r;
    status_i = s;
    ext_i    = r[0];
    tag_i    = t;
    aux_i    = aux_t'(r[7:4]);
  endtask

  task automatic wait_accept();
    bit ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (in_ready && !flush) ok = 1'b1;
      tick();
    end
    if (!ok) chk("accept_timeout", 64'(0), 64'(1));
    in_valid = 1'b0;
  endtask

  task automatic push_one(logic [63:0] r, logic [4:0] s, tag_t t);
    drive(r, s, t);
    wait_accept();
  endtask

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_result", result_o, 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    tick();

    // Single pass.
    out_ready = 1'b1;
    drive(64'hFFFF_FFFF_3F80_0000, 5'b00001, 3'd3);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("pass_fflags", 64'(fflags), 64'(5'b00001));
    chk("pass_count", 64'(count), 64'(0));

    // Backpressure fill: A, B accepted, C held off.
    out_ready = 1'b0;
    drive(64'hAAAA_0000_0000_0001, 5'b0, 3'd1);
    tick();
    drive(64'hBBBB_0000_0000_0002, 5'b0, 3'd2);
    tick();
    drive(64'hCCCC_0000_0000_0003, 5'b0, 3'd4);
    tick();
    tick();
    chk("bp_count", 64'(count), 64'(2));
    chk("bp_in_ready", 64'(in_ready), 64'(0));
    out_ready = 1'b1;
    wait_accept();
    repeat (3) tick();

    // Full while popping: push refused, accepted next cycle.
    out_ready = 1'b0;
    push_one(64'hD, 5'b0, 3'd5);
    push_one(64'hE, 5'b0, 3'd6);
    chk("full_count", 64'(count), 64'(2));
    drive(64'hF, 5'b0, 3'd7);
    out_ready = 1'b1;
    tick();
    chk("full_pop_count", 64'(count), 64'(1));
    tick();
    in_valid = 1'b0;
    chk("full_next_count", 64'(count), 64'(1));
    repeat (3) tick();

    // Sticky flags.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    push_one(64'h10, 5'b10000, 3'd0);
    push_one(64'h20, 5'b00100, 3'd0);
    repeat (3) tick();
    chk("sticky_or", 64'(fflags), 64'(5'b10100));
    out_ready = 1'b0;
    drive(64'h30, 5'b00001, 3'd1);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_with_pop", 64'(fflags), 64'(5'b00001));
    tick();

    // Flush with push and pop requested.
    out_ready = 1'b0;
    push_one(64'h40, 5'b11111, 3'd2);
    push_one(64'h50, 5'b11111, 3'd3);
    drive(64'h60, 5'b11111, 3'd4);
    out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_count", 64'(count), 64'(0));
    chk("flush_valid", 64'(out_valid), 64'(0));
    chk("flush_busy", 64'(busy), 64'(0));
    chk("flush_fflags", 64'(fflags), 64'(5'b00001));
    tick();

`ifdef FPNEW_SDOTP_OUT_FALL_THROUGH_EN
    // Zero-latency bypass on an empty buffer.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    out_ready = 1'b1;
    drive(64'h1234_5678_9ABC_DEF0, 5'b00010, 3'd6);
    #1;
    chk("ft_valid", 64'(out_valid), 64'(1));
    chk("ft_result", result_o, 64'h1234_5678_9ABC_DEF0);
    chk("ft_count", 64'(count), 64'(0));
    tick();
    in_valid = 1'b0;
    chk("ft_count_after", 64'(count), 64'(0));
    chk("ft_fflags", 64'(fflags), 64'(5'b00010));
    tick();
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      result_i  = {$urandom(), $urandom()};
      status_i  = 5'($urandom());
      ext_i     = 1'($urandom());
      tag_i     = tag_t'($urandom());
      aux_i     = aux_t'($urandom());
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      clr       = ($urandom_range(0, 15) == 0);
      tick();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    clr       = 1'b0;
    out_ready = 1'b1;
    repeat (DEPTH + 3) tick();
    chk("drained", 64'(sb.size()), 64'(0));

    mon_en = 1'b0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
